grid_display: RTL and testbench



---
 rtl/grid_display.sv | 136 +++++++++++++
 tb/tb_grid_display.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/grid_display.sv
// Pixel renderer for a ROWS x COLS grid of coloured cells on the VGA path.
// Two-stage pipeline: stage 1 classifies the pixel, stage 2 picks the colour.
module grid_display #(
   parameter  int ROWS         = 4,
   parameter  int COLS         = 4,
   parameter  int CELL         = 100,
   parameter  int GAP          = 4,
   parameter  int ORG_X        = 110,
   parameter  int ORG_Y        = 30,
   parameter  int CUR_T        = 4,
   parameter  int IND_W        = 4,
   parameter  int IND_H        = 11,
   parameter  int BLINK_FRAMES = 30,
   localparam int RW           = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW           = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [9:0]                x,
   input  logic [9:0]                y,
   input  logic                      video_on,
   input  logic                      error,
   input  logic [ROWS*COLS*12-1:0]   cells,
   input  logic                      cursor_en,
   input  logic [RW-1:0]             cursor_row,
   input  logic [CW-1:0]             cursor_col,
   output logic [11:0]               rgb
);

   localparam int P  = CELL + GAP;
   localparam int W  = COLS * P + GAP;
   localparam int H  = ROWS * P + GAP;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

   int          w_ox, w_oy, w_mx, w_my, w_lx, w_ly, w_col, w_row, w_cx, w_idx;
   logic        w_in_grid, w_gap, w_cell, w_edge, w_cur_ok, w_cur_hit, w_ind;
   logic        w_zero, w_frame_start;

   logic        r1_von, r1_err, r1_cell, r1_gap, r1_cur, r1_ind;
   logic [IW-1:0] r1_idx;
   logic        r_prev_zero, r_blink;
   logic [FW-1:0] r_frame_cnt;

   // Region classification, cursor-edge and indicator detection for the current sample
   always_comb begin
      w_ox      = int'(x) - ORG_X;
      w_oy      = int'(y) - ORG_Y;
      w_in_grid = (w_ox >= 0) && (w_ox < W) && (w_oy >= 0) && (w_oy < H);
      w_mx      = 0;
      w_my      = 0;
      w_col     = 0;
      w_row     = 0;
      if (w_in_grid) begin
         w_mx  = w_ox % P;
         w_my  = w_oy % P;
         w_col = w_ox / P;
         w_row = w_oy / P;
      end else begin
         w_mx  = 0;
         w_my  = 0;
      end
      w_gap  = w_in_grid && ((w_mx < GAP) || (w_my < GAP) ||
                             (w_ox >= COLS * P) || (w_oy >= ROWS * P));
      w_cell = w_in_grid && !w_gap;
      w_lx   = w_mx - GAP;
      w_ly   = w_my - GAP;
      w_edge = (w_lx < CUR_T) || (w_lx >= CELL - CUR_T) ||
               (w_ly < CUR_T) || (w_ly >= CELL - CUR_T);
      w_idx  = w_cell ? (w_row * COLS + w_col) : 0;
      // An out-of-range cursor suppresses both the outline and the indicator
      w_cur_ok  = cursor_en && (int'(cursor_row) < ROWS) && (int'(cursor_col) < COLS);
      w_cur_hit = w_cur_ok && w_cell && w_edge &&
                  (w_row == int'(cursor_row)) && (w_col == int'(cursor_col));
      w_cx  = ORG_X + int'(cursor_col) * P + GAP + CELL / 2;
      w_ind = w_cur_ok &&
              (int'(y) >= ORG_Y - IND_H) && (int'(y) < ORG_Y) &&
              (int'(x) >= w_cx - IND_W / 2) && (int'(x) < w_cx + IND_W / 2);
   end

   assign w_zero        = (x == 10'd0) && (y == 10'd0);
   assign w_frame_start = w_zero && !r_prev_zero;

   // Frame counter and blink phase, advanced once per entry into pixel (0,0)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_zero <= 1'b0;
         r_frame_cnt <= '0;
         r_blink     <= 1'b0;
      end else begin
         r_prev_zero <= w_zero;
         if (w_frame_start) begin
            if (int'(r_frame_cnt) >= BLINK_FRAMES - 1) begin
               r_frame_cnt <= '0;
               r_blink     <= ~r_blink;
            end else begin
               r_frame_cnt <= r_frame_cnt + FW'(1);
            end
         end
      end
   end

   // Stage 1: register classification flags and the qualifiers
   always_ff @(posedge clk) begin
      if (reset) begin
         r1_von  <= 1'b0;
         r1_err  <= 1'b0;
         r1_cell <= 1'b0;
         r1_gap  <= 1'b0;
         r1_cur  <= 1'b0;
         r1_ind  <= 1'b0;
         r1_idx  <= '0;
      end else begin
         r1_von  <= video_on;
         r1_err  <= error;
         r1_cell <= w_cell;
         r1_gap  <= w_gap;
         r1_cur  <= w_cur_hit;
         r1_ind  <= w_ind;
         r1_idx  <= w_idx[IW-1:0];
      end
   end

   // Stage 2: colour selection by priority; cell colours are read here
   always_ff @(posedge clk) begin
      if (reset)                  rgb <= 12'h000;
      else if (!r1_von)           rgb <= 12'h000;
      else if (r1_cur && !r_blink) rgb <= 12'hFF0;
      else if (r1_cell)           rgb <= cells[int'(r1_idx) * 12 +: 12];
      else if (r1_gap)            rgb <= 12'h7FF;
      else if (r1_ind)            rgb <= 12'hB70;
      else if (r1_err)            rgb <= 12'hA30;
      else                        rgb <= 12'h606;
   end

endmodule

// File: tb/tb_grid_display.sv
// Directed bench for grid_display: expectations queued at drive time and
// checked two cycles later; a second instance covers a 3-row grid.
module tb_grid_display;

   typedef struct {
      int          due;
      int          sel;
      logic [11:0] exp;
      string       tag;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [9:0]   x, y;
   logic         video_on, error, cursor_en;
   logic [191:0] cells_a;
   logic [143:0] cells_b;
   logic [1:0]   cur_row_a, cur_row_b, cur_col;
   logic [11:0]  rgb_a, rgb_b, obs;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t cur;

   grid_display #(.BLINK_FRAMES(2)) u_dut_a (
      .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on), .error(error),
      .cells(cells_a), .cursor_en(cursor_en), .cursor_row(cur_row_a),
      .cursor_col(cur_col), .rgb(rgb_a));

   grid_display #(.ROWS(3), .BLINK_FRAMES(2)) u_dut_b (
      .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on), .error(error),
      .cells(cells_b), .cursor_en(cursor_en), .cursor_row(cur_row_b),
      .cursor_col(cur_col), .rgb(rgb_b));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: pop every expectation that has come due and compare
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         cur = sb.pop_front();
         obs = (cur.sel == 0) ? rgb_a : rgb_b;
         n_tests++;
         assert ((obs === cur.exp) && (cur.due == cyc)) else begin
            n_fail++;
            $error("FAIL %s: rgb=%h expected=%h (due %0d, at %0d)",
                   cur.tag, obs, cur.exp, cur.due, cyc);
         end
      end
   end

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic pix(input int px, input int py);
      x = 10'(px);
      y = 10'(py);
   endtask

   task automatic chk(input int sel, input logic [11:0] e, input string tag);
      sb.push_back('{cyc + 2, sel, e, tag});
   endtask

   task automatic direct(input logic [11:0] o, input logic [11:0] e, input string tag);
      n_tests++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: rgb=%h expected=%h", tag, o, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; video_on = 1'b1; error = 1'b0; cursor_en = 1'b0;
      x = 10'd5; y = 10'd5;
      cur_row_a = 2'd0; cur_row_b = 2'd0; cur_col = 2'd0;
      cells_a = '0; cells_b = '0;
      cells_a[11*12 +: 12] = 12'h123;
      cells_a[5*12 +: 12]  = 12'h456;
      cells_a[0*12 +: 12]  = 12'h0A5;
      cells_b[10*12 +: 12] = 12'h789;

      @(posedge clk);
      repeat (3) begin
         nxt();
         direct(rgb_a, 12'h000, "reset_hold");
      end
      reset = 1'b0;
      chk(0, 12'h606, "post_reset_border");
      nxt();
      direct(rgb_a, 12'h000, "reset_flush");

      nxt(); pix(476, 292); chk(0, 12'h123, "cell_2_3");
      nxt(); pix(215, 80);  chk(0, 12'h7FF, "gap_vertical");
      nxt(); pix(5, 5);     chk(0, 12'h606, "border");
      nxt(); error = 1'b1;  chk(0, 12'hA30, "error_border");
      nxt(); error = 1'b0;  chk(0, 12'h606, "border_again");
      nxt(); pix(476, 292); video_on = 1'b0; chk(0, 12'h000, "video_off");
      nxt(); video_on = 1'b1; chk(0, 12'h123, "video_on");
      nxt(); pix(529, 100); chk(0, 12'h7FF, "grid_right_edge_gap");
      nxt(); pix(530, 100); chk(0, 12'h606, "grid_right_outside");
      nxt(); pix(113, 34);  chk(0, 12'h7FF, "outer_gap");
      nxt(); pix(114, 34);  chk(0, 12'h0A5, "cell_0_0_first_px");
      nxt(); pix(110, 29);  chk(0, 12'h606, "above_grid_no_cursor");

      // cells is read at stage 2: a change one cycle after the sample is seen
      nxt(); pix(476, 292); chk(0, 12'h321, "cells_stage2_sample");
      nxt(); cells_a[11*12 +: 12] = 12'h321;

      nxt(); cursor_en = 1'b1; cur_row_a = 2'd1; cur_col = 2'd1;
             pix(218, 138); chk(0, 12'hFF0, "cursor_corner");
      nxt(); pix(221, 188); chk(0, 12'hFF0, "cursor_left_lx3");
      nxt(); pix(222, 188); chk(0, 12'h456, "cursor_left_lx4");
      nxt(); pix(313, 188); chk(0, 12'h456, "cursor_right_lx95");
      nxt(); pix(314, 188); chk(0, 12'hFF0, "cursor_right_lx96");
      nxt(); pix(268, 141); chk(0, 12'hFF0, "cursor_top_ly3");
      nxt(); pix(268, 142); chk(0, 12'h456, "cursor_top_ly4");

      // Holding (0,0) three cycles is one frame: phase stays on
      nxt(); pix(0, 0); chk(0, 12'h606, "origin_border");
      nxt(); nxt();
      nxt(); pix(5, 5);
      nxt(); pix(218, 138); chk(0, 12'hFF0, "blink_hold_one_frame");
      nxt(); pix(0, 0);
      nxt(); pix(5, 5);
      nxt(); pix(218, 138); chk(0, 12'h456, "blink_off");
      nxt(); pix(0, 0);
      nxt(); pix(5, 5);
      nxt(); pix(218, 138); chk(0, 12'h456, "blink_off_frame3");
      nxt(); pix(0, 0);
      nxt(); pix(5, 5);
      nxt(); pix(218, 138); chk(0, 12'hFF0, "blink_on_again");

      nxt(); cur_row_a = 2'd0; cur_col = 2'd2;
             pix(372, 29); chk(0, 12'hB70, "ind_center");
      nxt(); pix(370, 29); chk(0, 12'hB70, "ind_left_edge");
      nxt(); pix(369, 29); chk(0, 12'h606, "ind_left_outside");
      nxt(); pix(374, 29); chk(0, 12'h606, "ind_right_outside");
      nxt(); pix(376, 29); chk(0, 12'h606, "ind_cx_plus_w");
      nxt(); pix(372, 19); chk(0, 12'hB70, "ind_top_row");
      nxt(); pix(372, 18); chk(0, 12'h606, "ind_above_band");
      nxt(); pix(372, 29); cursor_en = 1'b0; chk(0, 12'h606, "ind_disabled");

      nxt(); cursor_en = 1'b1; cur_row_b = 2'd3;
             pix(372, 29); chk(1, 12'h606, "oob_no_indicator");
             chk(0, 12'hB70, "ind_inrange_same_cycle");
      nxt(); pix(322, 242); chk(1, 12'h789, "oob_no_outline");
      nxt(); cur_row_b = 2'd2; chk(1, 12'hFF0, "rows3_outline");
      nxt(); pix(322, 345); chk(1, 12'h7FF, "rows3_bottom_gap");
      nxt(); pix(322, 346); chk(1, 12'h606, "rows3_below_grid");

      nxt(); pix(476, 292);
      repeat (3) nxt();
      direct(rgb_a, 12'h321, "pre_reset_cell");
      reset = 1'b1;
      nxt();
      direct(rgb_a, 12'h000, "midframe_reset");
      reset = 1'b0;

      repeat (4) nxt();
      n_tests++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
